// File: rtl/clic_irq_scheduler_if.sv
// Source-side and decode-side signals of the CLIC interrupt scheduler.
// The slave modport is the scheduler; the master modport drives the sources and consumes the request.
interface clic_irq_scheduler_if #(
   parameter int NumSrc     = 64,
   parameter int LevelWidth = 8
);
   logic [NumSrc-1:0]            src_i;
   logic [NumSrc-1:0]            src_edge_i;
   logic [NumSrc-1:0]            src_en_i;
   logic [NumSrc*LevelWidth-1:0] src_level_i;
   logic [NumSrc*2-1:0]          src_priv_i;
   logic                         irq_ack_i;
   logic [NumSrc-1:0]            clic_irq_o;
   logic [LevelWidth-1:0]        clic_irq_level_o;
   logic [1:0]                   clic_irq_priv_o;

   modport master (
      output src_i, src_edge_i, src_en_i, src_level_i, src_priv_i, irq_ack_i,
      input  clic_irq_o, clic_irq_level_o, clic_irq_priv_o
   );

   modport slave (
      input  src_i, src_edge_i, src_en_i, src_level_i, src_priv_i, irq_ack_i,
      output clic_irq_o, clic_irq_level_o, clic_irq_priv_o
   );
endinterface

// File: rtl/clic_irq_scheduler.sv
// Latches CLIC sources, picks the highest-level eligible one and holds it until the core acks.
// Only a strictly higher level preempts; a one-cycle gap follows every ack.
module clic_irq_scheduler #(
   parameter int NumSrc     = 64,
   parameter int LevelWidth = 8
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   clic_irq_scheduler_if.slave  bus
);
   localparam int IdW = $clog2(NumSrc);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_e;

   state_e                r_state;
   logic [NumSrc-1:0]     r_src_q;
   logic [NumSrc-1:0]     r_pending_q;
   logic [IdW-1:0]        r_sel_id;
   logic [NumSrc-1:0]     r_irq;
   logic [LevelWidth-1:0] r_irq_level;
   logic [1:0]            r_irq_priv;

   logic [LevelWidth-1:0] w_lvl [NumSrc];
   logic [NumSrc-1:0]     w_elig;
   logic [IdW-1:0]        w_win_id;
   logic [LevelWidth-1:0] w_win_lvl;
   logic [1:0]            w_win_priv;
   logic [NumSrc-1:0]     w_win_onehot;
   logic                  w_any;
   logic                  w_sel_elig;
   logic                  w_ack_req;
   logic [NumSrc-1:0]     w_clr;
   logic [NumSrc-1:0]     w_pend_next;

   // Per-source level unpacking and eligibility
   always_comb begin
      for (int j = 0; j < NumSrc; j++) begin
         w_lvl[j]  = bus.src_level_i[j*LevelWidth +: LevelWidth];
         w_elig[j] = r_pending_q[j] & bus.src_en_i[j] & (w_lvl[j] != {LevelWidth{1'b0}});
      end
   end

   // Max-level search; strict compare keeps the lowest index on ties
   always_comb begin
      w_win_id  = {IdW{1'b0}};
      w_win_lvl = {LevelWidth{1'b0}};
      w_any     = 1'b0;
      for (int j = 0; j < NumSrc; j++) begin
         if (w_elig[j] && (w_lvl[j] > w_win_lvl)) begin
            w_win_id  = IdW'(j);
            w_win_lvl = w_lvl[j];
            w_any     = 1'b1;
         end else begin
            w_win_lvl = w_win_lvl;
         end
      end
   end

   // In REQ r_irq is exactly onehot(r_sel_id), so it doubles as the ack clear mask
   assign w_win_priv   = bus.src_priv_i[{w_win_id, 1'b0} +: 2];
   assign w_win_onehot = {{(NumSrc-1){1'b0}}, 1'b1} << w_win_id;
   assign w_sel_elig   = w_elig[r_sel_id];
   assign w_ack_req    = bus.irq_ack_i & (r_state == REQ);
   assign w_clr        = w_ack_req ? r_irq : {NumSrc{1'b0}};
   assign w_pend_next  = (bus.src_edge_i & ((bus.src_i & ~r_src_q) | (r_pending_q & ~w_clr)))
                       | (~bus.src_edge_i & bus.src_i);

   // Source history and pending latches
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_src_q     <= {NumSrc{1'b0}};
         r_pending_q <= {NumSrc{1'b0}};
      end else begin
         r_src_q     <= bus.src_i;
         r_pending_q <= w_pend_next;
      end
   end

   // Selection FSM with registered request outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_sel_id    <= {IdW{1'b0}};
         r_irq       <= {NumSrc{1'b0}};
         r_irq_level <= {LevelWidth{1'b0}};
         r_irq_priv  <= 2'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state     <= REQ;
                  r_sel_id    <= w_win_id;
                  r_irq       <= w_win_onehot;
                  r_irq_level <= w_win_lvl;
                  r_irq_priv  <= w_win_priv;
               end else begin
                  r_state <= IDLE;
               end
            end
            REQ: begin
               if (bus.irq_ack_i) begin
                  r_state     <= GAP;
                  r_irq       <= {NumSrc{1'b0}};
                  r_irq_level <= {LevelWidth{1'b0}};
                  r_irq_priv  <= 2'd0;
               end else if (!w_sel_elig) begin
                  r_state     <= IDLE;
                  r_irq       <= {NumSrc{1'b0}};
                  r_irq_level <= {LevelWidth{1'b0}};
                  r_irq_priv  <= 2'd0;
               end else if (w_win_lvl > r_irq_level) begin
                  r_state     <= REQ;
                  r_sel_id    <= w_win_id;
                  r_irq       <= w_win_onehot;
                  r_irq_level <= w_win_lvl;
                  r_irq_priv  <= w_win_priv;
               end else begin
                  r_state <= REQ;
               end
            end
            GAP: begin
               r_state     <= IDLE;
               r_irq       <= {NumSrc{1'b0}};
               r_irq_level <= {LevelWidth{1'b0}};
               r_irq_priv  <= 2'd0;
            end
            default: begin
               r_state     <= IDLE;
               r_irq       <= {NumSrc{1'b0}};
               r_irq_level <= {LevelWidth{1'b0}};
               r_irq_priv  <= 2'd0;
            end
         endcase
      end
   end

   assign bus.clic_irq_o       = r_irq;
   assign bus.clic_irq_level_o = r_irq_level;
   assign bus.clic_irq_priv_o  = r_irq_priv;

endmodule

// File: tb/tb_clic_irq_scheduler.sv
// Directed and randomized checks of clic_irq_scheduler against a behavioural model.
module tb_clic_irq_scheduler;
   localparam int N  = 64;
   localparam int LW = 8;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   clic_irq_scheduler_if #(.NumSrc(N), .LevelWidth(LW)) bus ();

   clic_irq_scheduler #(.NumSrc(N), .LevelWidth(LW)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: which source is presented (-1 = none), gap flag, pending flags
   bit [N-1:0] m_pend;
   bit [N-1:0] m_srcd;
   int         m_sel;
   int         m_sel_lvl;
   int         m_sel_priv;
   bit         m_gap;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic int lvl_of(input int j);
      return int'(bus.src_level_i[j*LW +: LW]);
   endfunction

   task automatic model_reset();
      m_pend = '0; m_srcd = '0; m_sel = -1; m_sel_lvl = 0; m_sel_priv = 0; m_gap = 1'b0;
   endtask

   task automatic model_step();
      bit [N-1:0] elig;
      int best = -1;
      int best_lvl = 0;
      int old_sel = m_sel;
      bit ack = bus.irq_ack_i;
      for (int j = 0; j < N; j++) begin
         elig[j] = m_pend[j] && bus.src_en_i[j] && (lvl_of(j) != 0);
         if (elig[j] && lvl_of(j) > best_lvl) begin best = j; best_lvl = lvl_of(j); end
      end
      if (m_sel >= 0) begin
         if (ack) begin m_sel = -1; m_gap = 1'b1; end
         else if (!elig[m_sel]) m_sel = -1;
         else if (best_lvl > m_sel_lvl) m_sel = best;
      end else if (m_gap) begin
         m_gap = 1'b0;
      end else if (best >= 0) begin
         m_sel = best;
      end
      if (m_sel >= 0 && m_sel != old_sel) begin
         m_sel_lvl  = best_lvl;
         m_sel_priv = int'(bus.src_priv_i[2*m_sel +: 2]);
      end
      for (int j = 0; j < N; j++) begin
         if (bus.src_edge_i[j])
            m_pend[j] = (bus.src_i[j] && !m_srcd[j]) ||
                        (m_pend[j] && !(ack && old_sel == j));
         else
            m_pend[j] = bus.src_i[j];
      end
      m_srcd = bus.src_i;
   endtask

   task automatic cycle();
      logic [63:0] e_irq;
      @(posedge clk_i);
      model_step();
      @(negedge clk_i);
      e_irq = (m_sel >= 0) ? (64'd1 << m_sel) : 64'd0;
      chk("irq",   bus.clic_irq_o, e_irq);
      chk("level", 64'(bus.clic_irq_level_o), (m_sel >= 0) ? 64'(m_sel_lvl) : 64'd0);
      chk("priv",  64'(bus.clic_irq_priv_o),  (m_sel >= 0) ? 64'(m_sel_priv) : 64'd0);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic cfg(input int j, input bit e, input bit en, input int lvl, input int pv);
      bus.src_edge_i[j]         = e;
      bus.src_en_i[j]           = en;
      bus.src_level_i[j*LW +: LW] = LW'(lvl);
      bus.src_priv_i[2*j +: 2]  = 2'(pv);
   endtask

   task automatic ack_once();
      bus.irq_ack_i = 1'b1; cycle(); bus.irq_ack_i = 1'b0;
   endtask

   initial begin
      logic [63:0] onehot;
      bus.src_i = '0; bus.src_edge_i = '0; bus.src_en_i = '0;
      bus.src_level_i = '0; bus.src_priv_i = '0; bus.irq_ack_i = 1'b0;
      model_reset();
      repeat (3) @(negedge clk_i);
      chk("rst_irq", bus.clic_irq_o, 64'd0);
      chk("rst_lvl", 64'(bus.clic_irq_level_o), 64'd0);
      rst_ni = 1'b1;
      cycles(2);

      // 1: single edge pulse, held until ack, not re-presented
      cfg(5, 1'b1, 1'b1, 10, 3);
      bus.src_i[5] = 1'b1; cycle(); bus.src_i[5] = 1'b0; cycle();
      chk("t1_irq", bus.clic_irq_o, 64'h20);
      chk("t1_lvl", 64'(bus.clic_irq_level_o), 64'd10);
      chk("t1_priv", 64'(bus.clic_irq_priv_o), 64'd3);
      cycles(3);
      chk("t1_hold", bus.clic_irq_o, 64'h20);
      ack_once(); cycles(4);
      chk("t1_gone", bus.clic_irq_o, 64'd0);

      // 2: equal-level tie goes to lowest index, then the other after the gap
      cfg(3, 1'b1, 1'b1, 20, 1); cfg(9, 1'b1, 1'b1, 20, 0);
      bus.src_i[3] = 1'b1; bus.src_i[9] = 1'b1; cycle();
      bus.src_i[3] = 1'b0; bus.src_i[9] = 1'b0; cycle();
      chk("t2_first", bus.clic_irq_o, 64'h8);
      ack_once();
      chk("t2_gap", bus.clic_irq_o, 64'd0);
      cycle(); cycle();
      onehot = 64'd1 << 9;
      chk("t2_second", bus.clic_irq_o, onehot);
      ack_once(); cycles(2);

      // 3: strictly higher level preempts, equal does not
      cfg(2, 1'b0, 1'b1, 5, 1);
      bus.src_i[2] = 1'b1; cycles(2);
      chk("t3_lvl5", bus.clic_irq_o, 64'h4);
      cfg(40, 1'b1, 1'b1, 6, 3);
      bus.src_i[40] = 1'b1; cycle(); bus.src_i[40] = 1'b0; cycle();
      onehot = 64'd1 << 40;
      chk("t3_pre", bus.clic_irq_o, onehot);
      cfg(41, 1'b1, 1'b1, 6, 0);
      bus.src_i[41] = 1'b1; cycle(); bus.src_i[41] = 1'b0; cycles(2);
      chk("t3_nopre", bus.clic_irq_o, onehot);
      ack_once(); cycles(3);
      ack_once(); cycles(3);

      // 4: ack wins over a simultaneous higher-level candidate
      cfg(40, 1'b1, 1'b1, 200, 3);
      bus.src_i[40] = 1'b1; cycle(); bus.src_i[40] = 1'b0;
      bus.irq_ack_i = 1'b1; cycle(); bus.irq_ack_i = 1'b0;
      chk("t4_gap", bus.clic_irq_o, 64'd0);
      cycle();
      chk("t4_idle", bus.clic_irq_o, 64'd0);
      cycle();
      onehot = 64'd1 << 40;
      chk("t4_next", bus.clic_irq_o, onehot);
      chk("t4_lvl", 64'(bus.clic_irq_level_o), 64'd200);
      ack_once(); bus.src_i[2] = 1'b0; cycles(4);

      // 5: level source drop, disabled and level-0 sources never win
      cfg(7, 1'b0, 1'b1, 30, 1);
      bus.src_i[7] = 1'b1; cycles(2);
      chk("t5_on", bus.clic_irq_o, 64'h80);
      bus.src_i[7] = 1'b0; cycles(2);
      chk("t5_off", bus.clic_irq_o, 64'd0);
      cfg(8, 1'b1, 1'b0, 50, 3); cfg(10, 1'b1, 1'b1, 0, 3);
      bus.src_i[8] = 1'b1; bus.src_i[10] = 1'b1; cycle();
      bus.src_i[8] = 1'b0; bus.src_i[10] = 1'b0; cycles(4);
      chk("t5_inelig", bus.clic_irq_o, 64'd0);

      // 6: new edge coincident with ack is re-presented, then async reset mid-REQ
      cfg(11, 1'b1, 1'b1, 33, 2);
      bus.src_i[11] = 1'b1; cycle(); bus.src_i[11] = 1'b0; cycle();
      bus.src_i[11] = 1'b1; bus.irq_ack_i = 1'b1; cycle();
      bus.src_i[11] = 1'b0; bus.irq_ack_i = 1'b0; cycles(2);
      onehot = 64'd1 << 11;
      chk("t6_again", bus.clic_irq_o, onehot);
      #1 rst_ni = 1'b0;
      #1;
      chk("t6_rst_irq", bus.clic_irq_o, 64'd0);
      chk("t6_rst_lvl", 64'(bus.clic_irq_level_o), 64'd0);
      model_reset();
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      cycles(4);
      chk("t6_pend_clr", bus.clic_irq_o, 64'd0);

      // Randomized traffic
      for (int blk = 0; blk < 8; blk++) begin
         for (int j = 0; j < N; j++) begin
            int pick = int'($urandom % 6);
            int lv;
            case (pick)
               0: lv = 0;
               1: lv = 1;
               2: lv = 2;
               3: lv = 3;
               4: lv = 10;
               default: lv = 200;
            endcase
            cfg(j, 1'($urandom % 2), ($urandom % 4) != 0, lv, int'($urandom % 4));
         end
         for (int c = 0; c < 60; c++) begin
            for (int j = 0; j < N; j++)
               if ($urandom % 16 == 0) bus.src_i[j] = ~bus.src_i[j];
            bus.irq_ack_i = ($urandom % 4 == 0);
            cycle();
         end
      end
      bus.irq_ack_i = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
